// File: rtl/button_debounce_ev.sv
// Push-button front end: two-flop synchronizer, debounce FSM, and
// single-cycle press / release / long-press strobes.
module button_debounce_ev #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int LONG_CYCLES = 100000000,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rset,
  input  logic but_in,
  output logic but_deb_o,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  typedef enum logic [1:0] {
    REL,
    PRESS_WAIT,
    PRS,
    REL_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  state_t           state_q;
  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             long_done_q;
  logic             deb_q;
  logic             press_q;
  logic             rel_q;
  logic             long_q;

  always_ff @(posedge clk) begin
    if (rset) begin
      state_q     <= REL;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_done_q <= 1'b0;
      deb_q       <= 1'b1;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      s1_q    <= but_in;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      unique case (state_q)
        REL: begin
          deb_q <= 1'b1;
          if (!s2_q) begin
            state_q   <= PRESS_WAIT;
            deb_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (s2_q) begin
            state_q   <= REL;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q     <= PRS;
            deb_q       <= 1'b0;
            press_q     <= 1'b1;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        PRS: begin
          // hold_cnt freezes while away and stops after the long strobe
          if (s2_q) begin
            state_q   <= REL_WAIT;
            deb_cnt_q <= '0;
          end else if (!long_done_q && hold_cnt_q == LONG_LAST) begin
            long_q      <= 1'b1;
            long_done_q <= 1'b1;
          end else if (!long_done_q) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        REL_WAIT: begin
          if (!s2_q) begin
            state_q <= PRS;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q <= REL;
            deb_q   <= 1'b1;
            rel_q   <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        default: state_q <= REL;
      endcase
    end
  end

  assign but_deb_o     = deb_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_debounce_ev.sv
// Directed bench for button_debounce_ev with DEB_CYCLES=4, LONG_CYCLES=10.
// Vector k drives inputs before posedge k; outputs are sampled 1 ns after it.
module tb_button_debounce_ev;

  logic clk;
  logic rset;
  logic but_in;
  logic but_deb_o;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  int checks   = 0;
  int failures = 0;

  button_debounce_ev #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(10),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .rset         (rset),
    .but_in       (but_in),
    .but_deb_o    (but_deb_o),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic but;
    logic rst;
    logic deb;
    logic pr;
    logic rl;
    logic lg;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic b, logic r, logic d,
                              logic p, logic rl, logic lg);
    vec_t v;
    v.but = b;
    v.rst = r;
    v.deb = d;
    v.pr  = p;
    v.rl  = rl;
    v.lg  = lg;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    but_in = b;
    rset   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h",
               name, idx, act, exp);
    end
  endtask

  task automatic release_seq(input string name);
    for (int r = 0; r < 10; r++) begin
      step(1'b1, 1'b0);
      chk(name, r,
          {28'd0, but_deb_o, press_pulse, release_pulse, long_pulse},
          {28'd0, r >= 6, 1'b0, r == 6, 1'b0});
    end
  endtask

  initial begin
    int long_n;
    int long_at;
    int rel_n;
    int pr_n;
    int deb_hi;

    but_in = 1'b1;
    rset   = 1'b1;

    // reset and idle
    for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(1, 0, 1, 0, 0, 0);
    // bounce: 3-cycle segments never reach 4 stable cycles
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 3; i++) add(s % 2 == 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 0, 0);
    // clean press held 30 cycles: press at 6, long at 16
    for (int r = 0; r < 30; r++)
      add(0, 0, r < 6, r == 6, 0, r == 16);
    // release: strobe 6 cycles after edge
    for (int r = 0; r < 10; r++)
      add(1, 0, r >= 6, 0, r == 6, 0);

    foreach (tbl[k]) begin
      step(tbl[k].but, tbl[k].rst);
      chk("vec", k,
          {28'd0, but_deb_o, press_pulse, release_pulse, long_pulse},
          {28'd0, tbl[k].deb, tbl[k].pr, tbl[k].rl, tbl[k].lg});
    end

    // release bounce: glitch high on steps 10,11 (hold_cnt reaches 5)
    for (int s = 0; s < 7; s++) begin
      step(1'b0, 1'b0);
      chk("rb_press", s, {31'd0, press_pulse}, {31'd0, s == 6});
    end
    chk("rb_deb", 6, {31'd0, but_deb_o}, 32'd0);
    long_n  = 0;
    long_at = -1;
    rel_n   = 0;
    pr_n    = 0;
    deb_hi  = 0;
    for (int s = 7; s < 31; s++) begin
      step((s == 10 || s == 11), 1'b0);
      if (long_pulse === 1'b1) begin
        long_n++;
        long_at = s;
      end
      if (release_pulse !== 1'b0) rel_n++;
      if (press_pulse !== 1'b0) pr_n++;
      if (but_deb_o !== 1'b0) deb_hi++;
    end
    chk("rb_long_n", 0, long_n, 1);
    chk("rb_long_at", 0, long_at, 19);
    chk("rb_long_late", 0, {31'd0, long_at > 16}, 32'd1);
    chk("rb_rel_n", 0, rel_n, 0);
    chk("rb_press_n", 0, pr_n, 0);
    chk("rb_deb_hi", 0, deb_hi, 0);
    release_seq("rb_rel");

    // reset two cycles after press, button still held
    for (int s = 0; s < 7; s++) begin
      step(1'b0, 1'b0);
      chk("mr_press", s, {31'd0, press_pulse}, {31'd0, s == 6});
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("mr_rst", 0,
        {29'd0, but_deb_o, press_pulse, release_pulse},
        {29'd0, 1'b1, 1'b0, 1'b0});
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b0);
      chk("mr_after", j,
          {29'd0, but_deb_o, press_pulse, release_pulse},
          {29'd0, j < 6, j == 6, 1'b0});
    end
    release_seq("mr_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
